seq_state_gen: RTL and testbench

- Instruction-cycle sequencer for the relay CPU.
- Generates the 24-bit one-hot FSM state vector that the decode logic consumes as its state input.
- Advances one state per tick. Wraps to state_1 at the end of each instruction. Instruction length is set by the abort code fed back from decode: 8, 10, 12, 14 or 24 states.
- Handles start, halt and the idle/halted condition.

---
 rtl/seq_pkg.sv | 88 ++++++++
 rtl/seq_tick_gen.sv | 53 +++++
 rtl/seq_state_gen.sv | 115 +++++++++++
 tb/tb_seq_state_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared sequencer types, state constants and helpers
// Contents: NUM_STATES, abort_sel_e (instruction-length code from decode),
//   seq_st_e (IDLE/RUN), state_1..state_24 one-hot constants shared with the
//   decode logic, last_state() and idx_to_onehot() helpers.
package seq_pkg;

  localparam int NUM_STATES = 24;

  typedef enum logic [2:0] {
    ABORT_NONE = 3'd0,
    ABORT_8    = 3'd1,
    ABORT_10   = 3'd2,
    ABORT_12   = 3'd3,
    ABORT_14   = 3'd4
  } abort_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_st_e;

  localparam logic [NUM_STATES-1:0] state_1  = 24'h000001;
  localparam logic [NUM_STATES-1:0] state_2  = 24'h000002;
  localparam logic [NUM_STATES-1:0] state_3  = 24'h000004;
  localparam logic [NUM_STATES-1:0] state_4  = 24'h000008;
  localparam logic [NUM_STATES-1:0] state_5  = 24'h000010;
  localparam logic [NUM_STATES-1:0] state_6  = 24'h000020;
  localparam logic [NUM_STATES-1:0] state_7  = 24'h000040;
  localparam logic [NUM_STATES-1:0] state_8  = 24'h000080;
  localparam logic [NUM_STATES-1:0] state_9  = 24'h000100;
  localparam logic [NUM_STATES-1:0] state_10 = 24'h000200;
  localparam logic [NUM_STATES-1:0] state_11 = 24'h000400;
  localparam logic [NUM_STATES-1:0] state_12 = 24'h000800;
  localparam logic [NUM_STATES-1:0] state_13 = 24'h001000;
  localparam logic [NUM_STATES-1:0] state_14 = 24'h002000;
  localparam logic [NUM_STATES-1:0] state_15 = 24'h004000;
  localparam logic [NUM_STATES-1:0] state_16 = 24'h008000;
  localparam logic [NUM_STATES-1:0] state_17 = 24'h010000;
  localparam logic [NUM_STATES-1:0] state_18 = 24'h020000;
  localparam logic [NUM_STATES-1:0] state_19 = 24'h040000;
  localparam logic [NUM_STATES-1:0] state_20 = 24'h080000;
  localparam logic [NUM_STATES-1:0] state_21 = 24'h100000;
  localparam logic [NUM_STATES-1:0] state_22 = 24'h200000;
  localparam logic [NUM_STATES-1:0] state_23 = 24'h400000;
  localparam logic [NUM_STATES-1:0] state_24 = 24'h800000;

  // Codes 5-7 are not in the enum and fall through to the full 24 states.
  function automatic logic [4:0] last_state(input abort_sel_e sel);
    case (sel)
      ABORT_8:  return 5'd8;
      ABORT_10: return 5'd10;
      ABORT_12: return 5'd12;
      ABORT_14: return 5'd14;
      default:  return 5'd24;
    endcase
  endfunction

  function automatic logic [NUM_STATES-1:0] idx_to_onehot(input logic [4:0] idx);
    case (idx)
      5'd1:    return state_1;
      5'd2:    return state_2;
      5'd3:    return state_3;
      5'd4:    return state_4;
      5'd5:    return state_5;
      5'd6:    return state_6;
      5'd7:    return state_7;
      5'd8:    return state_8;
      5'd9:    return state_9;
      5'd10:   return state_10;
      5'd11:   return state_11;
      5'd12:   return state_12;
      5'd13:   return state_13;
      5'd14:   return state_14;
      5'd15:   return state_15;
      5'd16:   return state_16;
      5'd17:   return state_17;
      5'd18:   return state_18;
      5'd19:   return state_19;
      5'd20:   return state_20;
      5'd21:   return state_21;
      5'd22:   return state_22;
      5'd23:   return state_23;
      5'd24:   return state_24;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// rtl/seq_tick_gen.sv - sequencer tick prescaler with optional single-step
// Ports: clk, rst_n (async active-low), run (sequencer is in RUN),
//   step_mode/step (only with SEQ_SINGLE_STEP_EN), tick (advance this cycle).
// Optional macro: SEQ_SINGLE_STEP_EN adds step_mode/step single-step ticking.
module seq_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step_mode,
  input  logic step,
`endif
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_pre_tick;
  logic          w_src_tick;
  logic          w_cnt_en;

  assign w_pre_tick = (r_cnt == TERM);

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_step_d <= 1'b0;
    else        r_step_d <= step;
  end

  // In step mode the prescaler is frozen and each rising edge of step is one tick.
  assign w_src_tick = step_mode ? (step & ~r_step_d) : w_pre_tick;
  assign w_cnt_en   = ~step_mode;
`else
  assign w_src_tick = w_pre_tick;
  assign w_cnt_en   = 1'b1;
`endif

  assign tick = run & w_src_tick;

  // Held at zero while idle so every instruction starts a fresh prescale period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (!run)     r_cnt <= '0;
    else if (w_cnt_en) r_cnt <= w_pre_tick ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/seq_state_gen.sv
// rtl/seq_state_gen.sv - instruction-cycle sequencer producing one-hot state
// Ports: clk, rst_n (async active-low), start, halt_req, abort_sel[2:0],
//   step_mode/step (only with SEQ_SINGLE_STEP_EN), state_onehot[NUM_STATES],
//   state_idx[4:0], tick, instr_done, halted.
// Optional macro: SEQ_SINGLE_STEP_EN enables single-step ticking.
module seq_state_gen #(
  parameter int NUM_STATES = 24,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [2:0]            abort_sel,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step_mode,
  input  logic                  step,
`endif
  output logic [NUM_STATES-1:0] state_onehot,
  output logic [4:0]            state_idx,
  output logic                  tick,
  output logic                  instr_done,
  output logic                  halted
);

  import seq_pkg::abort_sel_e;
  import seq_pkg::seq_st_e;
  import seq_pkg::ST_IDLE;
  import seq_pkg::ST_RUN;
  import seq_pkg::last_state;
  import seq_pkg::idx_to_onehot;

  seq_st_e               r_st, w_next_st;
  logic [4:0]            r_idx, w_next_idx;
  logic [NUM_STATES-1:0] r_onehot;
  logic                  r_halt_latch, w_next_latch;
  logic                  w_tick;
  logic                  w_done;
  logic                  w_end;
  logic [4:0]            w_last;

  seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (r_st == ST_RUN),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .tick      (w_tick)
  );

  // abort_sel only matters when the current state equals its length; the last
  // state is always a hard end so the index can never reach NUM_STATES+1.
  assign w_last = last_state(abort_sel_e'(abort_sel));
  assign w_end  = (r_idx == w_last) || (r_idx == 5'(NUM_STATES));

  always_comb begin
    w_next_st    = r_st;
    w_next_idx   = r_idx;
    w_next_latch = r_halt_latch;
    w_done       = 1'b0;
    case (r_st)
      ST_IDLE: begin
        // halt_req is ignored here, so start+halt_req leaves the latch clear.
        if (start) begin
          w_next_st    = ST_RUN;
          w_next_idx   = 5'd1;
          w_next_latch = 1'b0;
        end
      end
      default: begin
        if (halt_req) w_next_latch = 1'b1;
        if (w_tick) begin
          if (w_end) begin
            w_done = 1'b1;
            if (r_halt_latch || halt_req) begin
              w_next_st    = ST_IDLE;
              w_next_idx   = 5'd0;
              w_next_latch = 1'b0;
            end else begin
              w_next_idx = 5'd1;
            end
          end else begin
            w_next_idx = r_idx + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st         <= ST_IDLE;
      r_idx        <= 5'd0;
      r_onehot     <= '0;
      r_halt_latch <= 1'b0;
    end else begin
      r_st         <= w_next_st;
      r_idx        <= w_next_idx;
      r_onehot     <= NUM_STATES'(idx_to_onehot(w_next_idx));
      r_halt_latch <= w_next_latch;
    end
  end

  assign state_onehot = r_onehot;
  assign state_idx    = r_idx;
  assign halted       = (r_st == ST_IDLE);
  assign tick         = w_tick;
  assign instr_done   = w_done;

  a_onehot_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(state_onehot) && ((state_idx == 5'd0) == (state_onehot == '0)));

endmodule

// File: tb/tb_seq_state_gen.sv
// tb/tb_seq_state_gen.sv - directed self-checking bench for seq_state_gen
module tb_seq_state_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [2:0]  abort_sel;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode;
  logic        step;
`endif

  logic [23:0] onehot, onehot4;
  logic [4:0]  idx, idx4;
  logic        tck, tck4, done, done4, hlt, hlt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_state_gen #(.NUM_STATES(24), .TICK_DIV(1)) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .halt_req (halt_req),
    .abort_sel (abort_sel),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode (step_mode), .step (step),
`endif
    .state_onehot (onehot), .state_idx (idx), .tick (tck),
    .instr_done (done), .halted (hlt)
  );

  seq_state_gen #(.NUM_STATES(24), .TICK_DIV(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .start (start), .halt_req (halt_req),
    .abort_sel (abort_sel),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode (step_mode), .step (step),
`endif
    .state_onehot (onehot4), .state_idx (idx4), .tick (tck4),
    .instr_done (done4), .halted (hlt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs 2*len cycles from state 1 checking the index sequence and done pulses.
  task automatic run_period(input logic [2:0] code, input int len);
    abort_sel = code;
    for (int k = 0; k < 2 * len; k++) begin
      check($sformatf("per%0d_idx", len), 32'(idx), 32'((k % len) + 1));
      check($sformatf("per%0d_done", len), 32'(done), 32'((k % len) == len - 1));
      clk_n(1);
    end
  endtask

  initial begin
    logic [23:0] exp_oh;
    rst_n     = 1'b0;
    start     = 1'b0;
    halt_req  = 1'b0;
    abort_sel = 3'd0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    clk_n(2);
    check("rst_halted", 32'(hlt), 32'd1);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_onehot", 32'(onehot), 32'd0);
    check("rst_tick", 32'(tck), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_halted4", 32'(hlt4), 32'd1);

    // Full 24-state instruction
    rst_n = 1'b1;
    clk_n(1);
    check("idle_hold", 32'(hlt), 32'd1);
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      exp_oh = 24'h1 << (k - 1);
      check("full_onehot", 32'(onehot), 32'(exp_oh));
      check("full_idx", 32'(idx), 32'(k));
      check("full_tick", 32'(tck), 32'd1);
      check("full_done", 32'(done), 32'(k == 24));
      clk_n(1);
    end
    check("full_wrap_onehot", 32'(onehot), 32'h000001);
    check("full_wrap_halted", 32'(hlt), 32'd0);

    // Shortened instructions
    run_period(3'd1, 8);
    run_period(3'd2, 10);
    run_period(3'd3, 12);
    run_period(3'd4, 14);
    run_period(3'd7, 24);

    // Abort code that appears only after its last state is passed
    abort_sel = 3'd0;
    clk_n(8);
    check("late_abort_idx9", 32'(idx), 32'd9);
    abort_sel = 3'd1;
    for (int k = 9; k <= 24; k++) begin
      check("late_abort_idx", 32'(idx), 32'(k));
      check("late_abort_done", 32'(done), 32'(k == 24));
      clk_n(1);
    end
    check("late_abort_wrap", 32'(idx), 32'd1);

    // Halt request pulse mid-instruction
    abort_sel = 3'd3;
    clk_n(2);
    check("halt_at3", 32'(idx), 32'd3);
    halt_req = 1'b1;
    clk_n(1);
    halt_req = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      check("halt_run_idx", 32'(idx), 32'(k));
      check("halt_run_done", 32'(done), 32'(k == 12));
      clk_n(1);
    end
    check("halt_halted", 32'(hlt), 32'd1);
    check("halt_onehot", 32'(onehot), 32'd0);
    check("halt_idx", 32'(idx), 32'd0);
    check("halt_tick", 32'(tck), 32'd0);
    clk_n(3);
    check("halt_stays", 32'(hlt), 32'd1);
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("restart_idx", 32'(idx), 32'd1);
    check("restart_halted", 32'(hlt), 32'd0);

    // Halt again, then start and halt_req together in idle
    halt_req = 1'b1;
    clk_n(1);
    halt_req = 1'b0;
    clk_n(11);
    check("halt2_halted", 32'(hlt), 32'd1);
    start    = 1'b1;
    halt_req = 1'b1;
    clk_n(1);
    start    = 1'b0;
    halt_req = 1'b0;
    check("both_idx", 32'(idx), 32'd1);
    clk_n(12);
    check("both_no_latch_idx", 32'(idx), 32'd1);
    check("both_no_latch_halted", 32'(hlt), 32'd0);

    // Asynchronous reset mid-instruction
    abort_sel = 3'd0;
    clk_n(16);
    check("pre_rst_idx17", 32'(idx), 32'd17);
    rst_n = 1'b0;
    #2;
    check("async_rst_halted", 32'(hlt), 32'd1);
    check("async_rst_idx", 32'(idx), 32'd0);
    check("async_rst_onehot", 32'(onehot), 32'd0);
    clk_n(1);
    rst_n = 1'b1;

    // Prescaled ticks
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("div4_idx", 32'(idx4), 32'(1 + c / 4));
      check("div4_tick", 32'(tck4), 32'((c % 4) == 3));
      clk_n(1);
    end

`ifdef SEQ_SINGLE_STEP_EN
    rst_n = 1'b0;
    clk_n(1);
    rst_n     = 1'b1;
    step_mode = 1'b1;
    start     = 1'b1;
    clk_n(1);
    start = 1'b0;
    clk_n(2);
    check("step_frozen_idx", 32'(idx), 32'd1);
    step = 1'b1;
    check("step_tick", 32'(tck), 32'd1);
    clk_n(10);
    check("step_held_tick", 32'(tck), 32'd0);
    step = 1'b0;
    check("step_one_advance", 32'(idx), 32'd2);
    step_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
